// File: rtl/digit_scan_sequencer.sv
// digit_scan_sequencer: free-running 4-digit scan controller.
// Steps the decoder select {a,b} through digits 0..3. Each digit is shown for
// DWELL cycles and then blanked for BLANK cycles. The nibbles come from a
// shadow register that is reloaded from the pending register only at frame
// boundaries, so every frame shows digits from one coherent display word.
module digit_scan_sequencer #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  output logic        a,
  output logic        b,
  output logic [3:0]  digit,
  output logic        blank,
  output logic        frame_done,
  output logic        update_pending
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      shadow;
  logic [15:0]      pending;

  // The registered select doubles as the digit index.
  logic [1:0]       idx;
  assign idx = {a, b};

  logic        frame_start;
  logic        step_show;
  logic        to_gap;
  logic        to_idle;
  logic        transfer;
  logic [1:0]  next_idx;
  logic [15:0] view;

  // Decode which transition (if any) happens on the coming edge.
  always_comb begin
    frame_start = 1'b0;
    step_show   = 1'b0;
    to_gap      = 1'b0;
    to_idle     = 1'b0;
    case (state)
      IDLE: frame_start = en;
      SHOW: to_gap = (cnt == DWELL_LAST);
      GAP: begin
        if (cnt == BLANK_LAST) begin
          if (idx != 2'd3) step_show   = 1'b1;
          else if (en)     frame_start = 1'b1;
          else             to_idle     = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase
    transfer = frame_start & update_pending;
    if (frame_start || to_idle) next_idx = 2'd0;
    else if (step_show)         next_idx = idx + 2'd1;
    else                        next_idx = idx;
    // The nibble latched on a frame-start edge must come from the word
    // being transferred on that same edge, not the outgoing shadow.
    view = transfer ? pending : shadow;
  end

  // FSM state and dwell/blank counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (frame_start || step_show) state <= SHOW;
      else if (to_gap)              state <= GAP;
      else if (to_idle)             state <= IDLE;

      if (state == IDLE || frame_start || step_show || to_gap || to_idle)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered outputs: select and digit move only when a digit is entered
  // (or cleared on the return to IDLE, while blank is already high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a          <= 1'b0;
      b          <= 1'b0;
      digit      <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_start;
      if (frame_start || step_show || to_idle) begin
        {a, b} <= next_idx;
        digit  <= view[{next_idx, 2'b00} +: 4];
      end
      if (frame_start || step_show) blank <= 1'b0;
      else if (to_gap || to_idle)   blank <= 1'b1;
    end
  end

  // Double buffer: load always lands in pending; shadow is refreshed at
  // frame start with the value pending held before that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow         <= '0;
      pending        <= '0;
      update_pending <= 1'b0;
    end else begin
      if (transfer) shadow <= pending;
      if (load)     pending <= data_in;
      if (load)          update_pending <= 1'b1;
      else if (transfer) update_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Testbench for digit_scan_sequencer: directed table, corner-case sequences
// and random stimulus checked against a frame-position reference model.
module tb_digit_scan_sequencer;

  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic        a;
  logic        b;
  logic [3:0]  digit;
  logic        blank;
  logic        frame_done;
  logic        update_pending;

  digit_scan_sequencer #(
    .DWELL(DW),
    .BLANK(BL),
    .CNT_W(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .load          (load),
    .data_in       (data_in),
    .a             (a),
    .b             (b),
    .digit         (digit),
    .blank         (blank),
    .frame_done    (frame_done),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: position within the frame, plus the two word registers.
  bit          m_idle;
  int          m_pos;
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  bit          m_upd;

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [1:0]  ab;
    logic [3:0]  digit;
    logic        blank;
    logic        fd;
    logic        upd;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idle   = 1'b1;
    m_pos    = 0;
    m_shadow = '0;
    m_pend   = '0;
    m_upd    = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [15:0] d);
    bit start;
    start = 1'b0;
    if (m_idle) begin
      if (e) start = 1'b1;
    end else if (m_pos == FRAME - 1) begin
      if (e) start = 1'b1;
      else   m_idle = 1'b1;
    end else begin
      m_pos++;
    end
    if (start) begin
      m_idle = 1'b0;
      m_pos  = 0;
      if (m_upd) begin
        m_shadow = m_pend;
        m_upd    = 1'b0;
      end
    end
    if (l) begin
      m_pend = d;
      m_upd  = 1'b1;
    end
  endtask

  task automatic check_model();
    int k;
    logic [1:0] e_ab;
    logic [3:0] e_digit;
    logic       e_blank;
    logic       e_fd;
    if (m_idle) begin
      e_ab    = 2'd0;
      e_digit = m_shadow[3:0];
      e_blank = 1'b1;
      e_fd    = 1'b0;
    end else begin
      k       = m_pos / SLOT;
      e_ab    = 2'(k);
      e_digit = 4'((m_shadow >> (4 * k)) & 16'hF);
      e_blank = (m_pos % SLOT) >= DW;
      e_fd    = (m_pos == 0);
    end
    chk("ab",    16'({a, b}),           16'(e_ab));
    chk("digit", 16'(digit),            16'(e_digit));
    chk("blank", 16'(blank),            16'(e_blank));
    chk("frame_done", 16'(frame_done),  16'(e_fd));
    chk("update_pending", 16'(update_pending), 16'(m_upd));
  endtask

  task automatic step(input logic e, input logic l, input logic [15:0] d);
    en      = e;
    load    = l;
    data_in = d;
    @(posedge clk);
    model_edge(e, l, d);
    #1;
    check_model();
  endtask

  // Advance with en held until the model sits at the given frame position.
  task automatic run_to(input int target, input logic e);
    int n;
    n = 0;
    while (!(!m_idle && m_pos == target) && n < 200) begin
      step(e, 1'b0, 16'h0);
      n++;
    end
    chk("run_to_bound", 16'(n < 200), 16'd1);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_blank", 16'(blank), 16'd1);
    chk("rst_ab",    16'({a, b}), 16'd0);
    chk("rst_digit", 16'(digit), 16'd0);
    chk("rst_upd",   16'(update_pending), 16'd0);
    chk("rst_fd",    16'(frame_done), 16'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    tbl[0]  = '{1'b0, 1'b1, 16'h4321, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 16'h0000, 2'd0, 4'h1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0000, 2'd0, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 2'd0, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 2'd0, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 2'd0, 4'h1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 2'd0, 4'h1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 4'h2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 4'h2, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 4'h2, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 2'd1, 4'h2, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 2'd1, 4'h2, 1'b1, 1'b0, 1'b0};

    reset   = 1'b1;
    en      = 1'b0;
    load    = 1'b0;
    data_in = '0;
    model_reset();
    #2;
    check_model();
    @(negedge clk);
    reset = 1'b0;

    // Load 4321, start scanning, first two digit slots.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].load, tbl[i].data);
      chk("tbl_ab",    16'({a, b}),          16'(tbl[i].ab));
      chk("tbl_digit", 16'(digit),           16'(tbl[i].digit));
      chk("tbl_blank", 16'(blank),           16'(tbl[i].blank));
      chk("tbl_fd",    16'(frame_done),      16'(tbl[i].fd));
      chk("tbl_upd",   16'(update_pending),  16'(tbl[i].upd));
    end

    // frame_done repeats one frame later.
    run_to(FRAME - 1, 1'b1);
    chk("t1_ab3", 16'({a, b}), 16'd3);
    step(1'b1, 1'b0, 16'h0);
    chk("t1_fd_repeat", 16'(frame_done), 16'd1);

    // Load mid-frame: current frame unaffected, next frame shows new word.
    run_to(SLOT, 1'b1);
    step(1'b1, 1'b1, 16'hABCD);
    chk("t2_upd", 16'(update_pending), 16'd1);
    run_to(2 * SLOT, 1'b1);
    chk("t2_old_digit2", 16'(digit), 16'h3);
    run_to(FRAME - 1, 1'b1);
    step(1'b1, 1'b0, 16'h0);
    chk("t2_new_digit0", 16'(digit), 16'hD);
    chk("t2_upd_clear", 16'(update_pending), 16'd0);

    // Two loads in one frame: last write wins.
    step(1'b1, 1'b1, 16'h1111);
    run_to(10, 1'b1);
    step(1'b1, 1'b1, 16'h2222);
    run_to(FRAME - 1, 1'b1);
    step(1'b1, 1'b0, 16'h0);
    chk("t3_digit", 16'(digit), 16'h2);

    // Load on the boundary edge while another word is pending.
    step(1'b1, 1'b1, 16'h5555);
    run_to(FRAME - 1, 1'b1);
    step(1'b1, 1'b1, 16'h6666);
    chk("t4_digit5", 16'(digit), 16'h5);
    chk("t4_upd_held", 16'(update_pending), 16'd1);
    run_to(FRAME - 1, 1'b1);
    step(1'b1, 1'b0, 16'h0);
    chk("t4_digit6", 16'(digit), 16'h6);

    // Drop en mid-frame: frame completes, then IDLE.
    run_to(SLOT, 1'b1);
    step(1'b0, 1'b0, 16'h0);
    n = 0;
    while (!m_idle && n < 100) begin
      step(1'b0, 1'b0, 16'h0);
      n++;
    end
    chk("t5_idle_bound", 16'(n < 100), 16'd1);
    chk("t5_blank", 16'(blank), 16'd1);
    chk("t5_ab", 16'({a, b}), 16'd0);
    chk("t5_fd", 16'(frame_done), 16'd0);
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    chk("t5_restart_fd", 16'(frame_done), 16'd1);
    chk("t5_restart_blank", 16'(blank), 16'd0);

    // Async reset mid-SHOW of digit 2 with a word pending.
    step(1'b1, 1'b1, 16'h7777);
    run_to(2 * SLOT + 1, 1'b1);
    async_reset();
    step(1'b1, 1'b0, 16'h0);
    chk("t6_digit0", 16'(digit), 16'h0);
    chk("t6_ab", 16'({a, b}), 16'd0);
    chk("t6_fd", 16'(frame_done), 16'd1);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) async_reset();
      step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) == 0), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
